// File: rtl/debounce_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_fsm                                                             |
// | Push-button debouncer: two-flop synchronizer and a tick-counting FSM.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module debounce_fsm #(
    parameter int TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    // The count is complete when an accepted tick arrives with this value held.
    localparam logic [3:0] c_last = 4'(TICKS - 1);

    logic       r_sync1;
    logic       r_sync2;
    state_t     r_state;
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= ZERO;
            r_cnt    <= 4'd0;
            db_level <= 1'b0;
            db_tick  <= 1'b0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            db_tick <= 1'b0;
            case (r_state)
                ZERO: begin
                    db_level <= 1'b0;
                    if (r_sync2) begin
                        r_state <= WAIT1;
                        r_cnt   <= 4'd0;
                    end
                end
                WAIT1: begin
                    // An input reversal takes priority over a coincident tick.
                    if (!r_sync2) begin
                        r_state  <= ZERO;
                        r_cnt    <= 4'd0;
                        db_level <= 1'b0;
                    end else if (tick) begin
                        if (r_cnt == c_last) begin
                            r_state  <= ONE;
                            r_cnt    <= 4'd0;
                            db_level <= 1'b1;
                            db_tick  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ONE: begin
                    db_level <= 1'b1;
                    if (!r_sync2) begin
                        r_state <= WAIT0;
                        r_cnt   <= 4'd0;
                    end
                end
                WAIT0: begin
                    if (r_sync2) begin
                        r_state  <= ONE;
                        r_cnt    <= 4'd0;
                        db_level <= 1'b1;
                    end else if (tick) begin
                        if (r_cnt == c_last) begin
                            r_state  <= ZERO;
                            r_cnt    <= 4'd0;
                            db_level <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= ZERO;
                    r_cnt    <= 4'd0;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_debounce_fsm                                                          |
// | Directed and randomized bench for debounce_fsm against a run-length model|
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_debounce_fsm;

    localparam int TICKS = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic sw = 1'b0;
    logic db_level;
    logic db_tick;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int phase = 0;
    int snap;

    // Reference: the level flips once the synchronized input has differed from
    // it for an unbroken run containing TICKS ticks after the run's first cycle.
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_level = 1'b0;
    logic m_pulse = 1'b0;
    int   m_run = 0;
    int   m_ticks = 0;

    always #5 clk = ~clk;

    debounce_fsm #(.TICKS(TICKS)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic s, input logic r, input logic t);
        logic sws;
        if (!r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_pulse = 1'b0;
            m_run = 0; m_ticks = 0;
        end else begin
            sws = m_s2;
            m_s2 = m_s1;
            m_s1 = s;
            m_pulse = 1'b0;
            if (sws != m_level) begin
                if (m_run > 0 && t) m_ticks++;
                m_run++;
                if (m_ticks == TICKS) begin
                    m_level = ~m_level;
                    m_pulse = m_level;
                    m_run = 0;
                    m_ticks = 0;
                end
            end else begin
                m_run = 0;
                m_ticks = 0;
            end
        end
    endtask

    task automatic step(input logic s, input logic r, input logic t);
        sw = s; reset = r; tick = t;
        @(posedge clk);
        model(s, r, t);
        #1;
        chk("db_level", 32'(db_level), 32'(m_level));
        chk("db_tick", 32'(db_tick), 32'(m_pulse));
        if (db_tick === 1'b1) pulses++;
    endtask

    // One cycle with the nominal tick every 10 clk.
    task automatic pstep(input logic s);
        step(s, 1'b1, phase == 9);
        phase = (phase + 1) % 10;
    endtask

    initial begin
        // Reset, with tick active to show it has no effect.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("reset_level", 32'(db_level), 32'd0);
        chk("reset_tick", 32'(db_tick), 32'd0);
        for (int i = 0; i < 20; i++) pstep(1'b0);

        // Clean press held 100 clk, then clean release.
        snap = pulses;
        for (int i = 0; i < 100; i++) pstep(1'b1);
        chk("clean_level", 32'(db_level), 32'd1);
        chk("clean_pulses", 32'(pulses - snap), 32'd1);
        for (int i = 0; i < 60; i++) pstep(1'b0);
        chk("release_level", 32'(db_level), 32'd0);

        // Bounce press: five toggles at 3-clk intervals, then hold.
        snap = pulses;
        for (int b = 0; b < 5; b++)
            for (int i = 0; i < 3; i++) pstep(b[0] ? 1'b0 : 1'b1);
        for (int i = 0; i < 60; i++) pstep(1'b1);
        chk("bounce_pulses", 32'(pulses - snap), 32'd1);

        // Release bounce from ONE: 15 clk low, then back high.
        snap = pulses;
        for (int i = 0; i < 15; i++) pstep(1'b0);
        for (int i = 0; i < 30; i++) pstep(1'b1);
        chk("relbounce_level", 32'(db_level), 32'd1);
        chk("relbounce_pulses", 32'(pulses - snap), 32'd0);
        for (int i = 0; i < 60; i++) pstep(1'b0);

        // Tick/reversal collision with cnt==2 in WAIT1.
        snap = pulses;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        chk("collide_level", 32'(db_level), 32'd0);
        chk("collide_pulses", 32'(pulses - snap), 32'd0);

        // Reset mid-count with sw held high.
        snap = pulses;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("midrst_level", 32'(db_level), 32'd0);
        chk("midrst_tick", 32'(db_tick), 32'd0);
        phase = 0;
        for (int i = 0; i < 50; i++) pstep(1'b1);
        chk("midrst_pulses", 32'(pulses - snap), 32'd1);
        for (int i = 0; i < 60; i++) pstep(1'b0);

        // Single-clk glitch.
        snap = pulses;
        pstep(1'b1);
        for (int i = 0; i < 40; i++) pstep(1'b0);
        chk("glitch_level", 32'(db_level), 32'd0);
        chk("glitch_pulses", 32'(pulses - snap), 32'd0);

        // Randomized: sticky sw with occasional flips, dense ticks, rare reset.
        begin
            logic s;
            s = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) s = ~s;
                step(s, $urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
